// File: rtl/cp0_unit_if.sv
// Bus between the M stage and coprocessor 0: mfc0/mtc0 access, exception
// inputs from the pipe and the flush/redirect request back to it.
interface cp0_unit_if;
   logic [4:0]  rd_addr;
   logic [4:0]  wr_addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] pc_m;
   logic        bd_m;
   logic [4:0]  excode_m;
   logic [5:0]  hwint;
   logic        eret;
   logic [31:0] rdata;
   logic [31:0] epc_out;
   logic        int_req;

   modport master (
      output rd_addr, wr_addr, wdata, we, pc_m, bd_m, excode_m, hwint, eret,
      input  rdata, epc_out, int_req
   );

   modport slave (
      input  rd_addr, wr_addr, wdata, we, pc_m, bd_m, excode_m, hwint, eret,
      output rdata, epc_out, int_req
   );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR, Cause, EPC and PRId, interrupt/exception arbitration
// and the single flush/redirect request to the pipeline.
module cp0_unit (
   input logic       clk,
   input logic       reset,
   cp0_unit_if.slave bus
);
   localparam logic [31:0] PRID = 32'h2018_0706;

   logic [5:0]  im_q;
   logic        exl_q;
   logic        ie_q;
   logic        bd_q;
   logic [5:0]  ip_q;
   logic [4:0]  exccode_q;
   logic [31:0] epc_q;

   logic        int_pend;
   logic        exc_pend;
   logic [31:0] victim_pc;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   // Pending-event arbitration and the EPC value captured on entry.
   always_comb begin
      int_pend  = (|(bus.hwint & im_q)) & ie_q & ~exl_q;
      exc_pend  = (bus.excode_m != 5'd0) & ~exl_q;
      victim_pc = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
   end

   assign bus.int_req = int_pend | exc_pend;
   assign bus.epc_out = epc_q;

   // Architectural views of SR and Cause; unimplemented bits read 0.
   always_comb begin
      sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
      cause_val = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};
   end

   // mfc0 read mux, always the pre-edge register contents.
   always_comb begin
      bus.rdata = 32'd0;
      case (bus.rd_addr)
         5'd12:   bus.rdata = sr_val;
         5'd13:   bus.rdata = cause_val;
         5'd14:   bus.rdata = epc_q;
         5'd15:   bus.rdata = PRID;
         default: bus.rdata = 32'd0;
      endcase
   end

   // State update: reset > exception entry > eret > mtc0.
   always_ff @(posedge clk) begin
      if (reset) begin
         im_q      <= 6'd0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         ip_q      <= 6'd0;
         exccode_q <= 5'd0;
         epc_q     <= 32'd0;
      end else begin
         ip_q <= bus.hwint;
         if (bus.int_req) begin
            exl_q     <= 1'b1;
            exccode_q <= int_pend ? 5'd0 : bus.excode_m;
            bd_q      <= bus.bd_m;
            epc_q     <= {victim_pc[31:2], 2'b00};
         end else if (bus.eret) begin
            exl_q <= 1'b0;
         end else if (bus.we) begin
            case (bus.wr_addr)
               5'd12: begin
                  im_q  <= bus.wdata[15:10];
                  exl_q <= bus.wdata[1];
                  ie_q  <= bus.wdata[0];
               end
               5'd14:   epc_q <= bus.wdata;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed vector bench for cp0_unit: each row drives one cycle of inputs
// and states the combinational outputs expected before the next edge.
module tb_cp0_unit;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_bad;

   cp0_unit_if bus ();

   cp0_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra;
      logic [31:0] pc;
      logic        bd;
      logic [4:0]  exc;
      logic [5:0]  hw;
      logic        eret;
      logic [31:0] e_rdata;
      logic        e_int;
      logic [31:0] e_epc;
   } vec_t;

   localparam int NV = 30;
   vec_t vec [NV];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.we       = v.we;
      bus.wr_addr  = v.wa;
      bus.wdata    = v.wd;
      bus.rd_addr  = v.ra;
      bus.pc_m     = v.pc;
      bus.bd_m     = v.bd;
      bus.excode_m = v.exc;
      bus.hwint    = v.hw;
      bus.eret     = v.eret;
   endtask

   initial begin
      // we wa wd ra pc bd exc hw eret | rdata int_req epc_out
      vec[0]  = '{1'b0, 5'd0, 32'h0, 5'd13, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0};
      vec[1]  = '{1'b0, 5'd0, 32'h0, 5'd12, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0};
      vec[2]  = '{1'b0, 5'd0, 32'h0, 5'd14, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0};
      vec[3]  = '{1'b0, 5'd0, 32'h0, 5'd15, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h2018_0706, 1'b0,
                  32'h0};
      vec[4]  = '{1'b0, 5'd0, 32'h0, 5'd16, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0};
      vec[5]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0, 1'b0,
                  32'h0};
      vec[6]  = '{1'b0, 5'd0, 32'h0, 5'd12, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0000_FC03, 1'b0,
                  32'h0};
      vec[7]  = '{1'b1, 5'd12, 32'h0000_FC01, 5'd12, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0000_FC03,
                  1'b0, 32'h0};
      // Interrupt on IP2 once SR is enabled.
      vec[8]  = '{1'b0, 5'd0, 32'h0, 5'd12, 32'h1000, 1'b0, 5'd0, 6'h04, 1'b0, 32'h0000_FC01, 1'b1,
                  32'h0};
      vec[9]  = '{1'b0, 5'd0, 32'h0, 5'd13, 32'h0, 1'b0, 5'd0, 6'h04, 1'b0, 32'h0000_1000, 1'b0,
                  32'h1000};
      vec[10] = '{1'b0, 5'd0, 32'h0, 5'd12, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0000_FC03, 1'b0,
                  32'h1000};
      // Masked by EXL, then eret lets the waiting interrupt through.
      vec[11] = '{1'b0, 5'd0, 32'h0, 5'd14, 32'h0, 1'b0, 5'd4, 6'h01, 1'b0, 32'h1000, 1'b0,
                  32'h1000};
      vec[12] = '{1'b0, 5'd0, 32'h0, 5'd13, 32'h0, 1'b0, 5'd0, 6'h01, 1'b1, 32'h0000_0400, 1'b0,
                  32'h1000};
      vec[13] = '{1'b0, 5'd0, 32'h0, 5'd12, 32'h2000, 1'b0, 5'd0, 6'h01, 1'b0, 32'h0000_FC01, 1'b1,
                  32'h1000};
      vec[14] = '{1'b0, 5'd0, 32'h0, 5'd14, 32'h0, 1'b0, 5'd0, 6'h00, 1'b1, 32'h2000, 1'b0,
                  32'h2000};
      vec[15] = '{1'b1, 5'd12, 32'h0000_FC00, 5'd13, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0, 1'b0,
                  32'h2000};
      // RI in a delay slot with IE = 0.
      vec[16] = '{1'b0, 5'd0, 32'h0, 5'd12, 32'h3008, 1'b1, 5'd10, 6'h00, 1'b0, 32'h0000_FC00, 1'b1,
                  32'h2000};
      vec[17] = '{1'b0, 5'd0, 32'h0, 5'd13, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h8000_0028, 1'b0,
                  32'h3004};
      vec[18] = '{1'b0, 5'd0, 32'h0, 5'd12, 32'h0, 1'b0, 5'd0, 6'h00, 1'b1, 32'h0000_FC02, 1'b0,
                  32'h3004};
      // mtc0 EPC and eret together with an AdES at pc 0 in a delay slot.
      vec[19] = '{1'b1, 5'd14, 32'h3100, 5'd14, 32'h0, 1'b1, 5'd5, 6'h00, 1'b1, 32'h3004, 1'b1,
                  32'h3004};
      vec[20] = '{1'b0, 5'd0, 32'h0, 5'd14, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'hFFFF_FFFC, 1'b0,
                  32'hFFFF_FFFC};
      vec[21] = '{1'b0, 5'd0, 32'h0, 5'd13, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h8000_0014, 1'b0,
                  32'hFFFF_FFFC};
      vec[22] = '{1'b0, 5'd0, 32'h0, 5'd12, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0000_FC02, 1'b0,
                  32'hFFFF_FFFC};
      vec[23] = '{1'b1, 5'd12, 32'h0000_FC01, 5'd12, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0000_FC02,
                  1'b0, 32'hFFFF_FFFC};
      // Interrupt and Ov together: interrupt wins, EPC low bits cleared.
      vec[24] = '{1'b0, 5'd0, 32'h0, 5'd14, 32'h5006, 1'b0, 5'd12, 6'h20, 1'b0, 32'hFFFF_FFFC, 1'b1,
                  32'hFFFF_FFFC};
      vec[25] = '{1'b0, 5'd0, 32'h0, 5'd13, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0000_8000, 1'b0,
                  32'h5004};
      vec[26] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 5'd14, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h5004, 1'b0,
                  32'h5004};
      vec[27] = '{1'b0, 5'd0, 32'h0, 5'd13, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0, 1'b0, 32'h5004};
      vec[28] = '{1'b1, 5'd12, 32'h0000_0401, 5'd12, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0, 32'h0000_FC03,
                  1'b0, 32'h5004};
      vec[29] = '{1'b0, 5'd0, 32'h0, 5'd12, 32'h0, 1'b0, 5'd0, 6'h3E, 1'b0, 32'h0000_0401, 1'b0,
                  32'h5004};

      n_vec = 0;
      n_bad = 0;

      // Reset with every hwint line high: IP must still come up 0.
      reset = 1'b1;
      drive('{1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 6'h3F, 1'b0, 32'h0, 1'b0, 32'h0});
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vec[i]);
         #1;
         check32($sformatf("v%0d rdata", i), bus.rdata, vec[i].e_rdata);
         check32($sformatf("v%0d int_req", i), {31'd0, bus.int_req}, {31'd0, vec[i].e_int});
         check32($sformatf("v%0d epc_out", i), bus.epc_out, vec[i].e_epc);
         @(negedge clk);
      end

      // Enter a handler, then reset in the middle of it.
      drive('{1'b0, 5'd0, 32'h0, 5'd12, 32'h7000, 1'b0, 5'd0, 6'h01, 1'b0, 32'h0, 1'b0, 32'h0});
      #1;
      check32("irq before mid reset", {31'd0, bus.int_req}, 32'd1);
      @(negedge clk);
      check32("epc in handler", bus.epc_out, 32'h7000);
      check32("irq masked in handler", {31'd0, bus.int_req}, 32'd0);
      reset = 1'b1;
      drive('{1'b1, 5'd14, 32'h1234, 5'd12, 32'h9000, 1'b1, 5'd12, 6'h3F, 1'b1, 32'h0, 1'b0,
              32'h0});
      @(negedge clk);
      reset = 1'b0;
      drive('{1'b0, 5'd0, 32'h0, 5'd12, 32'h0, 1'b0, 5'd0, 6'h3F, 1'b0, 32'h0, 1'b0, 32'h0});
      #1;
      check32("sr after mid reset", bus.rdata, 32'h0);
      check32("epc_out after mid reset", bus.epc_out, 32'h0);
      check32("irq after mid reset", {31'd0, bus.int_req}, 32'd0);
      bus.rd_addr = 5'd13;
      #1;
      check32("cause after mid reset", bus.rdata, 32'h0);
      bus.rd_addr = 5'd14;
      #1;
      check32("epc reg after mid reset", bus.rdata, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 block for the pipelined MIPS core; the consumer of the exception codes produced by the decode stage and carried down the pipe. It sits beside the memory (M) stage, takes the M-stage exception code, victim PC and delay-slot flag, merges them with six hardware interrupt lines, and raises a single flush/redirect request. It holds SR, Cause, EPC and PRId, serves mfc0/mtc0, and clears EXL on eret.

## Interface
- PRID, 32'h2018_0706, constant returned when reading register 15.
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- rd_addr  in  5  mfc0 source register number.
- wr_addr  in  5  mtc0 destination register number.
- wdata  in  32  mtc0 data.
- we  in  1  mtc0 write enable (M stage).
- pc_m  in  32  PC of the instruction in M.
- bd_m  in  1  instruction in M sits in a branch delay slot.
- excode_m  in  5  exception code of the instruction in M; 0 = none, 10 = RI, 4/5 = AdEL/AdES, 12 = Ov.
- hwint  in  6  hardware interrupt lines, level-sensitive.
- eret  in  1  eret in M.
- rdata  out  32  combinational read of register rd_addr.
- epc_out  out  32  current EPC, to the PC-select mux for eret.
- int_req  out  1  combinational; flush pipeline and redirect PC to 32'h0000_4180.

## Operation
- Registers (others read 0, writes ignored):
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0; not writable by mtc0.
  - EPC (14): 32 bits, writable by mtc0.
  - PRId (15): PRID, read-only.
- IP[15:10] is loaded from hwint every cycle, including during exception entry.
- int_pend = |(hwint & IM) & IE & ~EXL.
- exc_pend = (excode_m != 0) & ~EXL.
- int_req = int_pend | exc_pend.
- Exception entry on an edge where int_req = 1:
  - EXL <= 1.
  - ExcCode <= int_pend ? 0 : excode_m. An interrupt has priority over a synchronous exception.
  - BD <= bd_m.
  - EPC <= {bd_m ? pc_m-4 : pc_m}[31:2], 2'b00.
- eret with int_req = 0: EXL <= 0 on that edge. epc_out is already valid before the edge.
- mtc0 with we = 1 and int_req = 0: write SR (IM, EXL, IE fields only) or EPC.
- Priority on the same edge: exception entry > eret > mtc0.
  - An mtc0 or eret coinciding with int_req is discarded; the pipeline flushes it.
- rdata reflects pre-edge values. An mfc0 and mtc0 to the same register in the same cycle returns the old value; the pipeline handles forwarding.

## Timing
- Reset: SR = 0, Cause = 0, EPC = 0; rdata = 0 for registers 12–14; epc_out = 0; int_req = 0.
  - hwint is ignored in the reset cycle: IP becomes 0.
- int_req is combinational from hwint/excode_m/SR in the same cycle; no added latency.
- State updates at the next rising edge. After entry, int_req drops in the following cycle because EXL = 1.
- While EXL = 1, all new interrupts and exceptions are masked, and excode_m of any instruction is ignored.
- Reset asserted mid-handler: reset wins over every other event. EXL is cleared and the EPC value is lost.
- pc_m-4 wraps modulo 2^32 (pc_m = 0 with bd_m = 1 gives EPC = 32'hFFFF_FFFC).

## Test plan
- Reset, then read regs 12/13/14/15 -> 0, 0, 0, 32'h2018_0706; int_req = 0.
- mtc0 SR = 32'h0000_FC01, hwint = 6'b000100 -> int_req = 1 in the same cycle. Next cycle: Cause = 32'h0000_1000, EXL = 1, EPC = pc_m, int_req = 0.
- excode_m = 10, pc_m = 32'h0000_3008, bd_m = 1, IE = 0 -> int_req = 1. Next cycle: EPC = 32'h0000_3004, Cause = 32'h8000_0028.
- Interrupt and excode_m = 12 in the same cycle -> ExcCode = 0, and EPC is taken from pc_m.
- While EXL = 1: raise hwint and excode_m = 4 -> int_req stays 0. Then eret -> EXL = 0 next cycle, and the pending interrupt raises int_req one cycle later.
- mtc0 EPC = 32'h0000_3100 and eret together with int_req = 1 -> both discarded; EPC receives the exception value and EXL = 1.
